// File: rtl/ir_pkg.sv
// Shared constants and field helpers for the instruction queue.
// Exports default widths, the count-width function and opcode/operand extractors.
package ir_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_OPCODE_W = 4;
    localparam int DEF_DEPTH    = 4;

    // Extractors work on a wide zero-extended word so one pair of
    // functions serves every DATA_W / OPCODE_W combination.
    localparam int MAX_W = 64;

    function automatic int ir_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [MAX_W-1:0] ir_opcode(
        input logic [MAX_W-1:0] instr,
        input int               data_w,
        input int               opcode_w
    );
        return instr >> (data_w - opcode_w);
    endfunction

    function automatic logic [MAX_W-1:0] ir_operand(
        input logic [MAX_W-1:0] instr,
        input int               data_w,
        input int               opcode_w
    );
        logic [MAX_W-1:0] mask;
        mask = ~({MAX_W{1'b1}} << (data_w - opcode_w));
        return instr & mask;
    endfunction

endpackage

// File: rtl/ir_fifo.sv
// In-order prefetch FIFO: DEPTH x DATA_W storage with separate occupancy count.
// Ports: clk, n_clear, clr, push, pop, din -> head, count, full, empty.
module ir_fifo
    import ir_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = ir_cnt_w(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              n_clear,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_clear) begin
        if (!n_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr)
            mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/instr_queue.sv
// Instruction register with prefetch queue, bypass on empty, sticky overflow.
// Ports: clk, n_clear, flush, n_load, bus_in, n_next, n_enable -> opcode,
//        valid, bus_out, bus_oe, count, full, empty, overflow.
module instr_queue
    import ir_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OPCODE_W = DEF_OPCODE_W,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       n_clear,
    input  logic                       flush,
    input  logic                       n_load,
    input  logic [DATA_W-1:0]          bus_in,
    input  logic                       n_next,
    input  logic                       n_enable,
    output logic [OPCODE_W-1:0]        opcode,
    output logic                       valid,
    output logic [DATA_W-1:0]          bus_out,
    output logic                       bus_oe,
    output logic [ir_cnt_w(DEPTH)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int CNT_W  = ir_cnt_w(DEPTH);
    localparam int OPER_W = DATA_W - OPCODE_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] cur;
    logic [DATA_W-1:0] head;

    logic load;
    logic retire;
    logic refill;
    logic pop;
    logic bypass;
    logic push_req;
    logic push;
    logic drop;

    assign valid    = (state == HOLD);
    assign load     = !n_load;
    assign retire   = !n_next && valid;
    assign refill   = !valid || retire;
    assign pop      = refill && !empty;
    // Bypass only when nothing older is queued, preserving order.
    assign bypass   = refill && empty && load;
    assign push_req = load && !bypass;
    // A pop on the same edge frees a slot even when full.
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && !push;

    ir_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .n_clear (n_clear),
        .clr     (flush),
        .push    (push && !flush),
        .pop     (pop && !flush),
        .din     (bus_in),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge n_clear) begin
        if (!n_clear) begin
            state    <= IDLE;
            cur      <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            state    <= IDLE;
            cur      <= '0;
            overflow <= 1'b0;
        end else begin
            if (refill) begin
                if (pop) begin
                    cur   <= head;
                    state <= HOLD;
                end else if (bypass) begin
                    cur   <= bus_in;
                    state <= HOLD;
                end else begin
                    cur   <= '0;
                    state <= IDLE;
                end
            end
            if (drop)
                overflow <= 1'b1;
        end
    end

    logic [MAX_W-1:0] cur_ext;
    logic [MAX_W-1:0] op_ext;
    logic [MAX_W-1:0] opr_ext;

    assign cur_ext = MAX_W'(cur);
    assign op_ext  = ir_opcode(cur_ext, DATA_W, OPCODE_W);
    assign opr_ext = ir_operand(cur_ext, DATA_W, OPCODE_W);

    logic unused_bits;
    assign unused_bits = ^{op_ext[MAX_W-1:OPCODE_W],
                           opr_ext[MAX_W-1:OPER_W]};

    assign opcode  = valid ? op_ext[OPCODE_W-1:0] : '0;
    assign bus_oe  = !n_enable && valid;
    assign bus_out = bus_oe ? DATA_W'(opr_ext[OPER_W-1:0]) : '0;

endmodule
